// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and default widths for the register-file access controller.
// The writeback entry layout is fixed by the default widths below.
package rf_ctrl_pkg;

   localparam int RF_ADDR_W   = 6;
   localparam int RF_DATA_W   = 32;
   localparam int RF_WB_DEPTH = 2;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_READ  = 2'd1,
      ARB_WRITE = 2'd2
   } arb_e;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of decode, writeback and register-file signals seen by the controller.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface regfile_access_ctrl_if
   import rf_ctrl_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int DATA_W = RF_DATA_W
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both 1; ready never depends on a future valid, and the requester holds its
   // payload stable until it sees ready. rsp_valid has no backpressure.
   logic              rd_req_valid;
   logic              rd_req_ready;
   logic [ADDR_W-1:0] rd_rs_addr;
   logic [ADDR_W-1:0] rd_rt_addr;

   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rs;
   logic [DATA_W-1:0] rsp_rt;

   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   logic [ADDR_W-1:0] rf_rs_addr;
   logic [ADDR_W-1:0] rf_rt_addr;
   logic [ADDR_W-1:0] rf_rd_addr;
   logic              rf_write;
   logic [DATA_W-1:0] rf_data_in;
   logic [DATA_W-1:0] rf_rs;
   logic [DATA_W-1:0] rf_rt;

   modport slave (
      input  rd_req_valid, rd_rs_addr, rd_rt_addr,
      input  wb_valid, wb_addr, wb_data,
      input  rf_rs, rf_rt,
      output rd_req_ready, rsp_valid, rsp_rs, rsp_rt, wb_ready,
      output rf_rs_addr, rf_rt_addr, rf_rd_addr, rf_write, rf_data_in
   );

   modport master (
      output rd_req_valid, rd_rs_addr, rd_rt_addr,
      output wb_valid, wb_addr, wb_data,
      output rf_rs, rf_rt,
      input  rd_req_ready, rsp_valid, rsp_rs, rsp_rt, wb_ready,
      input  rf_rs_addr, rf_rt_addr, rf_rd_addr, rf_write, rf_data_in
   );

endinterface

// File: rtl/regfile_access_ctrl_wb_fifo.sv
// Small writeback FIFO; exposes per-entry valid/address so the read path can
// detect read-after-write hazards against every buffered writeback.
module regfile_wb_fifo
   import rf_ctrl_pkg::*;
#(
   parameter int DEPTH = RF_WB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               i_push,
   input  wb_entry_t                          i_entry,
   input  logic                               i_pop,
   output wb_entry_t                          o_head,
   output logic                               o_full,
   output logic                               o_empty,
   output logic [CNT_W-1:0]                   o_count,
   output logic [DEPTH-1:0]                   o_valid,
   output logic [DEPTH-1:0][RF_ADDR_W-1:0]    o_addr
);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [DEPTH-1:0] r_valid;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         // Push and pop never target the same slot: that needs full and empty at once.
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push_ok && (r_wr_ptr == PTR_W'(i)))
               r_valid[i] <= 1'b1;
            else if (w_pop_ok && (r_rd_ptr == PTR_W'(i)))
               r_valid[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_entry;
   end

   always_comb begin
      o_addr = '0;
      for (int i = 0; i < DEPTH; i++) o_addr[i] = r_mem[i].addr;
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_valid = r_valid;

endmodule

// File: rtl/regfile_access_ctrl.sv
// Serialises operand reads and buffered writebacks onto the single register
// file port, stalling reads that would overtake a buffered writeback.
module regfile_access_ctrl
   import rf_ctrl_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int DATA_W   = RF_DATA_W,
   parameter int WB_DEPTH = RF_WB_DEPTH
) (
   input logic                 clock,
   input logic                 reset,
   regfile_access_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(WB_DEPTH) + 1;

   arb_e                                w_arb;
   wb_entry_t                           w_push_entry;
   wb_entry_t                           w_head;
   logic                                w_full;
   logic                                w_empty;
   logic                                w_hazard;
   logic                                w_push;
   logic                                w_pop;
   logic [CNT_W-1:0]                    w_count;
   logic [WB_DEPTH-1:0]                 w_ent_valid;
   logic [WB_DEPTH-1:0][RF_ADDR_W-1:0]  w_ent_addr;
   logic [ADDR_W-1:0]                   w_rs_addr;
   logic [ADDR_W-1:0]                   w_rt_addr;
   logic [ADDR_W-1:0]                   w_wb_addr;
   logic [DATA_W-1:0]                   w_wb_data;
   logic                                r_rsp_valid;

   assign w_rs_addr    = bus.rd_rs_addr;
   assign w_rt_addr    = bus.rd_rt_addr;
   assign w_wb_addr    = bus.wb_addr;
   assign w_wb_data    = bus.wb_data;
   assign w_push_entry = '{addr: w_wb_addr, data: w_wb_data};

   // A writeback accepted alongside an issued read is pushed after the read,
   // so that read correctly sees the older value.
   assign w_push = bus.wb_valid && bus.wb_ready;
   assign w_pop  = (w_arb == ARB_WRITE);

   regfile_wb_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_wb_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count),
      .o_valid (w_ent_valid),
      .o_addr  (w_ent_addr)
   );

   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (w_ent_valid[i] &&
             ((w_ent_addr[i] == w_rs_addr) || (w_ent_addr[i] == w_rt_addr)))
            w_hazard = 1'b1;
      end
   end

   // Full FIFO drains first so a hazard stall is bounded by the FIFO depth.
   // Nothing is issued while reset is held, so decode never sees a lost accept.
   always_comb begin
      w_arb = ARB_IDLE;
      if (reset)
         w_arb = ARB_IDLE;
      else if (w_full)
         w_arb = ARB_WRITE;
      else if (bus.rd_req_valid && !w_hazard)
         w_arb = ARB_READ;
      else if (!w_empty)
         w_arb = ARB_WRITE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_rsp_valid <= 1'b0;
      else       r_rsp_valid <= (w_arb == ARB_READ);
   end

   assign bus.rd_req_ready = (w_arb == ARB_READ);
   assign bus.wb_ready     = (w_count < CNT_W'(WB_DEPTH));
   assign bus.rf_write     = (w_arb == ARB_WRITE);
   assign bus.rf_rs_addr   = w_rs_addr;
   assign bus.rf_rt_addr   = w_rt_addr;
   assign bus.rf_rd_addr   = w_head.addr;
   assign bus.rf_data_in   = w_head.data;
   assign bus.rsp_valid    = r_rsp_valid;
   assign bus.rsp_rs       = bus.rf_rs;
   assign bus.rsp_rt       = bus.rf_rt;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register-file model, directed scenarios and
// randomized traffic checked against an architectural reference model.
module tb_regfile_access_ctrl;
   import rf_ctrl_pkg::*;

   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } pend_t;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset;
   initial clock = 1'b0;
   always #5 clock = ~clock;

   regfile_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   regfile_access_ctrl #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .WB_DEPTH (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Synchronous register file: one read or one write per edge.
   logic [DW-1:0] rf_mem [64];
   always @(posedge clock) begin
      if (bus.rf_write) rf_mem[bus.rf_rd_addr] <= bus.rf_data_in;
      else begin
         bus.rf_rs <= rf_mem[bus.rf_rs_addr];
         bus.rf_rt <= rf_mem[bus.rf_rt_addr];
      end
   end

   // ---------------- reference model / scoreboard ----------------
   logic [2*DW-1:0] exp_q[$];
   pend_t           pend_q[$];
   logic [DW-1:0]   committed [64];
   bit              rsp_due;
   int              n_checks;
   int              n_pass;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Newest accepted value of a register, whether or not it has reached the file.
   function automatic logic [DW-1:0] latest(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = committed[a];
      foreach (pend_q[i]) if (pend_q[i].addr == a) v = pend_q[i].data;
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit rv, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bus.rd_req_valid = rv;
      bus.rd_rs_addr   = rs;
      bus.rd_rt_addr   = rt;
      bus.wb_valid     = wv;
      bus.wb_addr      = wa;
      bus.wb_data      = wd;
   endtask

   // One clock: predict the port decision from the arbitration rules, check it,
   // then advance the model. Called at posedge+1, returns at the next posedge+1.
   task automatic step(output bit rd_done, output bit wb_done);
      bit hz, exp_rd, exp_wr, exp_wbr;
      pend_t p;
      hz = 0; exp_rd = 0; exp_wr = 0;
      @(negedge clock); #1;
      foreach (pend_q[i])
         if (pend_q[i].addr == bus.rd_rs_addr || pend_q[i].addr == bus.rd_rt_addr) hz = 1;
      exp_wbr = (pend_q.size() < 2);
      if (pend_q.size() == 2)            exp_wr = 1;
      else if (bus.rd_req_valid && !hz) exp_rd = 1;
      else if (pend_q.size() != 0)       exp_wr = 1;
      chk("rd_req_ready", 64'(bus.rd_req_ready), 64'(exp_rd));
      chk("rf_write", 64'(bus.rf_write), 64'(exp_wr));
      chk("wb_ready", 64'(bus.wb_ready), 64'(exp_wbr));
      if (exp_wr)
         chk("rf_write_addr_data", 64'({bus.rf_rd_addr, bus.rf_data_in}),
             64'({pend_q[0].addr, pend_q[0].data}));
      if (exp_rd) begin
         chk("rf_read_addr", 64'({bus.rf_rs_addr, bus.rf_rt_addr}),
             64'({bus.rd_rs_addr, bus.rd_rt_addr}));
         exp_q.push_back({latest(bus.rd_rs_addr), latest(bus.rd_rt_addr)});
      end
      rsp_due = exp_rd;
      if (exp_wr) begin
         committed[pend_q[0].addr] = pend_q[0].data;
         void'(pend_q.pop_front());
      end
      wb_done = bus.wb_valid && exp_wbr;
      if (wb_done) begin
         p.addr = bus.wb_addr;
         p.data = bus.wb_data;
         pend_q.push_back(p);
      end
      rd_done = exp_rd;
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      bit rd, wd;
      drive(0, '0, '0, 0, '0, '0);
      for (int i = 0; i < n; i++) step(rd, wd);
   endtask

   // Present a read and/or writeback, holding each until the model says it is taken.
   task automatic hold(input bit rv, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bit rp, wp, rd, wdn;
      int n;
      rp = rv; wp = wv; n = 0;
      while ((rp || wp) && n < 12) begin
         drive(rp, rs, rt, wp, wa, wd);
         step(rd, wdn);
         if (rd)  rp = 0;
         if (wdn) wp = 0;
         n++;
      end
      chk("hold_accepted", 64'({rp, wp}), 64'(0));
      drive(0, '0, '0, 0, '0, '0);
   endtask

   // Asynchronous reset asserted mid-cycle; buffered writebacks are dropped.
   task automatic do_reset();
      #2 reset = 1'b1;
      drive(0, '0, '0, 0, '0, '0);
      rsp_due = 0;
      exp_q.delete();
      pend_q.delete();
      @(negedge clock); #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_rf_write", 64'(bus.rf_write), 64'(0));
      chk("rst_wb_ready", 64'(bus.wb_ready), 64'(1));
      chk("rst_rd_req_ready", 64'(bus.rd_req_ready), 64'(0));
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   // ---------------- response monitor ----------------
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clock);
         if (rsp_due || bus.rsp_valid)
            chk("rsp_valid_timing", 64'(bus.rsp_valid), 64'(rsp_due));
         if (bus.rsp_valid) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 64'(1), 64'(0));
            else begin
               e = exp_q.pop_front();
               chk("rsp_data", 64'({bus.rsp_rs, bus.rsp_rt}), e);
            end
         end else if (rsp_due && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      bit rp, wp, rd, wdn;
      logic [AW-1:0] rs, rt, wa;
      logic [DW-1:0] wd;
      n_checks = 0;
      n_pass   = 0;
      rsp_due  = 0;
      reset    = 1'b1;
      for (int i = 0; i < 64; i++) begin
         rf_mem[i]    = 32'hA500_0000 + 32'(i);
         committed[i] = 32'hA500_0000 + 32'(i);
      end
      rf_mem[3] = 32'd19; committed[3] = 32'd19;
      rf_mem[2] = 32'd0;  committed[2] = 32'd0;
      drive(0, '0, '0, 0, '0, '0);
      @(posedge clock); #1;
      do_reset();

      // Plain read of preloaded registers.
      hold(1, 6'd3, 6'd2, 0, '0, '0);
      idle(2);

      // Writeback then dependent read: stalls one cycle behind the write.
      hold(0, '0, '0, 1, 6'd5, 32'hDEAD_BEEF);
      hold(1, 6'd5, 6'd0, 0, '0, '0);
      idle(2);

      // Same-cycle writeback and read of r7: read sees the old value.
      hold(1, 6'd7, 6'd7, 1, 6'd7, 32'h11);
      hold(1, 6'd7, 6'd7, 0, '0, '0);
      idle(2);

      // Three writebacks against a pending non-hazard read fill the FIFO.
      hold(0, '0, '0, 1, 6'd20, 32'h2020_0001);
      hold(1, 6'd10, 6'd11, 1, 6'd21, 32'h2121_0002);
      hold(1, 6'd12, 6'd13, 1, 6'd22, 32'h2222_0003);
      hold(1, 6'd20, 6'd21, 0, '0, '0);
      hold(1, 6'd22, 6'd22, 0, '0, '0);
      idle(2);

      // One buffered write waits behind a stream of non-hazard reads.
      hold(0, '0, '0, 1, 6'd30, 32'h3030_3030);
      for (int k = 0; k < 6; k++) hold(1, 6'(8 + k), 6'(9 + k), 0, '0, '0);
      idle(1);
      hold(1, 6'd30, 6'd0, 0, '0, '0);
      idle(3);

      // Reset with two buffered writebacks and a read just issued.
      hold(1, 6'd1, 6'd2, 1, 6'd40, 32'h4040_0040);
      hold(1, 6'd3, 6'd4, 1, 6'd41, 32'h4141_0041);
      do_reset();
      idle(3);
      hold(1, 6'd40, 6'd41, 0, '0, '0);
      idle(2);

      // Randomized traffic over a small address window to provoke hazards.
      rp = 0; wp = 0; rs = '0; rt = '0; wa = '0; wd = '0;
      for (int c = 0; c < 1500; c++) begin
         if (c == 800) begin
            do_reset();
            rp = 0; wp = 0;
         end
         if (!rp && $urandom_range(0, 9) < 6) begin
            rp = 1;
            rs = 6'($urandom_range(0, 7));
            rt = 6'($urandom_range(0, 7));
         end
         if (!wp && $urandom_range(0, 9) < 5) begin
            wp = 1;
            wa = 6'($urandom_range(0, 7));
            wd = $urandom;
         end
         drive(rp, rs, rt, wp, wa, wd);
         step(rd, wdn);
         if (rd)  rp = 0;
         if (wdn) wp = 0;
      end
      idle(4);
      for (int a = 0; a < 8; a++) hold(1, 6'(a), 6'(7 - a), 0, '0, '0);
      idle(3);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
